// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU behind a start/busy/done handshake.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for op 101.
module alu_seq #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             illegal,
    output logic             busy,
    output logic             done,
    output logic             dbg_state
);
    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_t           state_q;
    logic [WIDTH-1:0] r_q;
    logic             c_q, v_q, zero_q, illegal_q, busy_q, done_q;

    logic [WIDTH:0]   sum_add, sum_sub;
    logic             ovf_add, ovf_sub;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_r_d;
    logic             alu_c_d, alu_v_d, alu_ill_d;

    assign shamt   = b[SHW-1:0];
    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // Sub overflow: second operand is ~b, so "same sign" means a and b differ in sign.
    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        alu_r_d   = '0;
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
        alu_ill_d = 1'b0;
        case (op)
            OP_AND: alu_r_d = a & b;
            OP_OR:  alu_r_d = a | b;
            OP_ADD: begin
                alu_r_d = sum_add[WIDTH-1:0];
                alu_c_d = sum_add[WIDTH];
                alu_v_d = ovf_add;
            end
            OP_SUB: begin
                alu_r_d = sum_sub[WIDTH-1:0];
                alu_c_d = sum_sub[WIDTH];
                alu_v_d = ovf_sub;
            end
            OP_SLT: alu_r_d = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ ovf_sub};
            OP_SLL: alu_r_d = a << shamt;
            OP_SRL: alu_r_d = a >> shamt;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: alu_ill_d = 1'b0;
`else
            OP_MUL: alu_ill_d = 1'b1;
`endif
            default: alu_r_d = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
    logic [2*WIDTH-1:0] acc_q, mcand_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW-1:0]     cnt_q;

    assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
`endif

    // Handshake: start is sampled only in IDLE; done pulses for exactly one cycle
    // after r and flags are written, and everything is held until the next done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef ALU_SEQ_MUL_EN
                    if (start && op == OP_MUL) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a};
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= MUL;
                    end else
`endif
                    if (start) begin
                        r_q       <= alu_r_d;
                        c_q       <= alu_c_d;
                        v_q       <= alu_v_d;
                        zero_q    <= (alu_r_d == '0);
                        illegal_q <= alu_ill_d;
                        done_q    <= 1'b1;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        r_q       <= acc_d[WIDTH-1:0];
                        v_q       <= |acc_d[2*WIDTH-1:WIDTH];
                        c_q       <= 1'b0;
                        zero_q    <= (acc_d[WIDTH-1:0] == '0);
                        illegal_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r         = r_q;
    assign c_out     = c_q;
    assign overflow  = v_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = (state_q == MUL);
endmodule
